// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command driver: opcode encoding,
// driver FSM states and the default datapath width.
package alu_pkg;

   localparam int DATA_W = 8;

   // Opcode encoding understood by the combinational ALU.
   typedef enum logic [2:0] {
      ADD = 3'b000,
      SUB = 3'b001,
      SLL = 3'b010,
      LSR = 3'b011,
      AND = 3'b100,
      OR  = 3'b101,
      XOR = 3'b110,
      EQL = 3'b111
   } alu_op_e;

   // Driver sequencing: wait for a command, hold operands, present response.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      RESP  = 2'd2
   } drv_state_e;

   // Width of the settle down-counter; covers SETTLE_CYCLES-1 up to 14.
   localparam int SETTLE_W = 4;

endpackage : alu_pkg

// File: rtl/alu_cmd_driver_if.sv
// Command and response valid/ready ports of the ALU command driver.
// The driver is the slave; whoever issues commands is the master.
interface alu_cmd_driver_if #(
   parameter int DATA_W = alu_pkg::DATA_W
);

   // Command channel
   logic                cmd_valid_i;
   logic                cmd_ready_o;
   logic [DATA_W-1:0]   cmd_a_i;
   logic [DATA_W-1:0]   cmd_b_i;
   alu_pkg::alu_op_e    cmd_op_i;
   logic [DATA_W-1:0]   cmd_exp_i;
   logic                cmd_chk_i;

   // Response channel
   logic                rsp_valid_o;
   logic                rsp_ready_i;
   logic [DATA_W-1:0]   rsp_res_o;
   alu_pkg::alu_op_e    rsp_op_o;
   logic                rsp_err_o;

   modport slave (
      input  cmd_valid_i, cmd_a_i, cmd_b_i, cmd_op_i, cmd_exp_i, cmd_chk_i,
      output cmd_ready_o,
      output rsp_valid_o, rsp_res_o, rsp_op_o, rsp_err_o,
      input  rsp_ready_i
   );

   modport master (
      output cmd_valid_i, cmd_a_i, cmd_b_i, cmd_op_i, cmd_exp_i, cmd_chk_i,
      input  cmd_ready_o,
      input  rsp_valid_o, rsp_res_o, rsp_op_o, rsp_err_o,
      output rsp_ready_i
   );

endinterface : alu_cmd_driver_if

// File: rtl/alu_cmd_driver_sat_counter.sv
// Saturating up-counter with synchronous clear. Clear has priority over
// increment; the count sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   // Count events, hold at all-ones, clear on request.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_o <= '0;
      end else if (clr_i) begin
         cnt_o <= '0;
      end else if (inc_i && (cnt_o != '1)) begin
         cnt_o <= cnt_o + W'(1);
      end
   end

endmodule : sat_counter

// File: rtl/alu_cmd_driver.sv
// Sequential initiator for an 8-bit combinational ALU. Accepts a command,
// drives the ALU from registers, waits SETTLE_CYCLES, captures the result,
// optionally compares it with an expected value and returns a response.
// Checked results are tallied in two saturating pass/fail counters.
module alu_cmd_driver
   import alu_pkg::*;
#(
   parameter int DATA_W        = alu_pkg::DATA_W,
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   alu_cmd_driver_if.slave   bus,
   output logic [DATA_W-1:0] alu_a_o,
   output logic [DATA_W-1:0] alu_b_o,
   output alu_op_e           alu_op_o,
   input  logic [DATA_W-1:0] alu_res_i,
   input  logic              clr_cnt_i,
   output logic [CNT_W-1:0]  pass_cnt_o,
   output logic [CNT_W-1:0]  fail_cnt_o
);

   // The settle counter is only SETTLE_W bits wide, so reject values it
   // cannot represent at elaboration time.
   if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 15)) begin : g_bad_settle
      $error("alu_cmd_driver: SETTLE_CYCLES must be in 1..15");
   end

   localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

   drv_state_e           state;
   logic [SETTLE_W-1:0]  settle;
   logic [DATA_W-1:0]    exp_q;
   logic                 chk_q;

   logic                 capture;
   logic                 mismatch;
   logic                 pass_inc;
   logic                 fail_inc;

   // The capture edge is the last DRIVE cycle; the comparison uses the live
   // ALU result so the counters and rsp_err_o see the same value.
   assign capture  = (state == DRIVE) && (settle == '0);
   assign mismatch = chk_q && (alu_res_i != exp_q);
   assign pass_inc = capture && chk_q && !mismatch;
   assign fail_inc = capture && mismatch;

   // Command/drive/response sequencing with all outputs registered.
   // NOTE: every register here is assigned with <= so each edge sees the
   // pre-edge values of its neighbours; mixing in = would make the result
   // depend on statement order inside the block.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state           <= IDLE;
         settle          <= '0;
         exp_q           <= '0;
         chk_q           <= 1'b0;
         alu_a_o         <= '0;
         alu_b_o         <= '0;
         alu_op_o        <= ADD;
         bus.cmd_ready_o <= 1'b1;
         bus.rsp_valid_o <= 1'b0;
         bus.rsp_res_o   <= '0;
         bus.rsp_op_o    <= ADD;
         bus.rsp_err_o   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               // ALU operands keep their last values while idle.
               if (bus.cmd_valid_i) begin
                  alu_a_o         <= bus.cmd_a_i;
                  alu_b_o         <= bus.cmd_b_i;
                  alu_op_o        <= bus.cmd_op_i;
                  exp_q           <= bus.cmd_exp_i;
                  chk_q           <= bus.cmd_chk_i;
                  settle          <= SETTLE_LOAD;
                  bus.cmd_ready_o <= 1'b0;
                  state           <= DRIVE;
               end
            end

            DRIVE: begin
               if (settle != '0) begin
                  settle <= settle - SETTLE_W'(1);
               end else begin
                  bus.rsp_res_o   <= alu_res_i;
                  bus.rsp_op_o    <= alu_op_o;
                  bus.rsp_err_o   <= mismatch;
                  bus.rsp_valid_o <= 1'b1;
                  state           <= RESP;
               end
            end

            RESP: begin
               // Response fields stay frozen until the consumer takes them.
               if (bus.rsp_ready_i) begin
                  bus.rsp_valid_o <= 1'b0;
                  bus.cmd_ready_o <= 1'b1;
                  state           <= IDLE;
               end
            end

            default: begin
               bus.rsp_valid_o <= 1'b0;
               bus.cmd_ready_o <= 1'b1;
               state           <= IDLE;
            end
         endcase
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_pass_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (clr_cnt_i),
      .inc_i  (pass_inc),
      .cnt_o  (pass_cnt_o)
   );

   sat_counter #(
      .W (CNT_W)
   ) u_fail_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (clr_cnt_i),
      .inc_i  (fail_inc),
      .cnt_o  (fail_cnt_o)
   );

endmodule : alu_cmd_driver
